// File: rtl/spi_slave_ctrl.sv
`timescale 1ns/1ps
// spi_slave_ctrl
// SPI mode-0 slave that decodes 5-byte control frames
// (command, address hi/lo, data hi/lo) into register-bus strobes.
//
// Ports
//   clk_osc_bufg    in   system clock
//   reset_osc_bufg  in   asynchronous reset, active-high
//   i_spi_clk       in   SPI clock (asynchronous)
//   i_spi_cs        in   chip select (asynchronous, polarity from SPI_CS_POL)
//   i_spi_mosi      in   master-out data (asynchronous)
//   o_spi_miso      out  slave-out data, 0 outside the read data phase
//   o_wr_en         out  one-cycle register write strobe
//   o_rd_en         out  one-cycle register read request
//   ov_addr         out  register address of the last decoded frame
//   ov_wr_data      out  write data, valid with o_wr_en
//   iv_rd_data      in   read data, sampled one clock after o_rd_en
//   o_cmd_err       out  one-cycle pulse on an unknown command byte
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | CS inactive, counters held at zero
// CMD     | assembling byte 0 (command)
// ADDR    | assembling bytes 1-2 (address)
// DATA    | write: assembling bytes 3-4; read: shifting 16 bits out MISO
// SKIP    | frame finished or rejected, ignore SCLK until CS drops

module spi_slave_ctrl #(
    parameter string      SPI_FIRST_DATA = "MSB",
    parameter string      SPI_CS_POL     = "LOW",
    parameter logic [7:0] CMD_WR         = 8'h80,
    parameter logic [7:0] CMD_RD         = 8'h81
) (
    input  logic        clk_osc_bufg,
    input  logic        reset_osc_bufg,
    input  logic        i_spi_clk,
    input  logic        i_spi_cs,
    input  logic        i_spi_mosi,
    output logic        o_spi_miso,
    output logic        o_wr_en,
    output logic        o_rd_en,
    output logic [15:0] ov_addr,
    output logic [15:0] ov_wr_data,
    input  logic [15:0] iv_rd_data,
    output logic        o_cmd_err
);

    localparam bit LSB_FIRST = (SPI_FIRST_DATA == "LSB");
    localparam bit CS_HIGH   = (SPI_CS_POL == "HIGH");

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_SKIP
    } state_t;

    state_t      state;
    logic [2:0]  sclk_sync;
    logic [2:0]  cs_sync;
    logic [2:0]  mosi_sync;
    logic        sclk_rise;
    logic        sclk_fall;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic [7:0]  shift_q;
    logic [7:0]  addr_hi;
    logic [7:0]  data_hi;
    logic        is_rd;
    logic [15:0] miso_sr;

    logic        cs_act;
    logic [7:0]  rx_byte;
    logic [15:0] rd_load;

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k] = x[7-k];
        end
        return r;
    endfunction

    // Stage [2] of every synchronizer is the edge-detect flop; using it for
    // CS and MOSI too keeps all three aligned with the registered edge pulses.
    assign cs_act = CS_HIGH ? cs_sync[2] : ~cs_sync[2];

    always_comb begin
        rx_byte = LSB_FIRST ? {mosi_sync[2], shift_q[7:1]} : {shift_q[6:0], mosi_sync[2]};
        // MISO always shifts out miso_sr[15]; pre-reverse each byte for LSB-first.
        rd_load = LSB_FIRST ? {rev8(iv_rd_data[15:8]), rev8(iv_rd_data[7:0])} : iv_rd_data;
    end

    always_ff @(posedge clk_osc_bufg or posedge reset_osc_bufg) begin
        if (reset_osc_bufg) begin
            sclk_sync <= 3'b000;
            cs_sync   <= {3{~CS_HIGH}};
            mosi_sync <= 3'b000;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], i_spi_clk};
            cs_sync   <= {cs_sync[1:0], i_spi_cs};
            mosi_sync <= {mosi_sync[1:0], i_spi_mosi};
            sclk_rise <= sclk_sync[1] & ~sclk_sync[2];
            sclk_fall <= ~sclk_sync[1] & sclk_sync[2];
        end
    end

    always_ff @(posedge clk_osc_bufg or posedge reset_osc_bufg) begin
        if (reset_osc_bufg) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 3'd0;
            shift_q    <= 8'h00;
            addr_hi    <= 8'h00;
            data_hi    <= 8'h00;
            is_rd      <= 1'b0;
            miso_sr    <= 16'h0000;
            o_spi_miso <= 1'b0;
            o_wr_en    <= 1'b0;
            o_rd_en    <= 1'b0;
            o_cmd_err  <= 1'b0;
            ov_addr    <= 16'h0000;
            ov_wr_data <= 16'h0000;
        end else begin
            o_wr_en   <= 1'b0;
            o_rd_en   <= 1'b0;
            o_cmd_err <= 1'b0;

            // The bank answers one clock after the request.
            if (o_rd_en) begin
                miso_sr <= rd_load;
            end

            // CS release outranks any SCLK edge seen in the same cycle.
            if (!cs_act) begin
                state      <= ST_IDLE;
                bit_cnt    <= 3'd0;
                byte_cnt   <= 3'd0;
                o_spi_miso <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_CMD;
                    ST_SKIP: state <= ST_SKIP;
                    default: begin
                        if (sclk_rise) begin
                            shift_q <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_cnt <= byte_cnt + 3'd1;
                                case (state)
                                    ST_CMD: begin
                                        if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
                                            is_rd <= (rx_byte == CMD_RD);
                                            state <= ST_ADDR;
                                        end else begin
                                            o_cmd_err <= 1'b1;
                                            state     <= ST_SKIP;
                                        end
                                    end
                                    ST_ADDR: begin
                                        if (byte_cnt == 3'd1) begin
                                            addr_hi <= rx_byte;
                                        end else begin
                                            ov_addr <= {addr_hi, rx_byte};
                                            o_rd_en <= is_rd;
                                            state   <= ST_DATA;
                                        end
                                    end
                                    default: begin
                                        if (byte_cnt == 3'd3) begin
                                            data_hi <= rx_byte;
                                        end else begin
                                            if (!is_rd) begin
                                                o_wr_en    <= 1'b1;
                                                ov_wr_data <= {data_hi, rx_byte};
                                            end
                                            // 16th read bit has just been sampled by the master.
                                            o_spi_miso <= 1'b0;
                                            state      <= ST_SKIP;
                                        end
                                    end
                                endcase
                            end
                        end else if (sclk_fall && state == ST_DATA && is_rd) begin
                            o_spi_miso <= miso_sr[15];
                            miso_sr    <= {miso_sr[14:0], 1'b0};
                        end
                    end
                endcase
            end
        end
    end

endmodule
